// File: rtl/apex7_po_event_capture_if.sv
// Producer/consumer bundle for the apex7 po event-capture stage.
// The slave modport is the capture block; the master modport is the harness side.
interface apex7_po_event_capture_if #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [36:0]      po_vec;
  logic             sample;
  logic             ev_valid;
  logic             ev_ready;
  logic [36:0]      ev_vec;
  logic [TS_W-1:0]  ev_ts;
  logic             ev_first;
  logic [LW-1:0]    level;
  logic             ovf;
  logic [CNT_W-1:0] ovf_cnt;

  modport slave (
    input  po_vec, sample, ev_ready,
    output ev_valid, ev_vec, ev_ts, ev_first, level, ovf, ovf_cnt
  );

  modport master (
    output po_vec, sample, ev_ready,
    input  ev_valid, ev_vec, ev_ts, ev_first, level, ovf, ovf_cnt
  );
endinterface

// File: rtl/apex7_po_event_capture.sv
// Samples the apex7 po vector, timestamps every change and queues it in a small
// FIFO for a valid/ready consumer; a full FIFO drops and counts, never stalls.
module apex7_po_event_capture #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  apex7_po_event_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [36:0]     vec;
    logic [TS_W-1:0] ts;
    logic            first;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           push_entry, head_d, head_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [TS_W-1:0]  ts_q;
  logic [36:0]      last_q;
  logic             first_q, ev_valid_q, ovf_q;
  logic [CNT_W-1:0] ovf_cnt_q;
  logic             pop, want_push, push, drop;

  always_comb begin
    pop        = (level_q != '0) && bus.ev_ready;
    want_push  = bus.sample && (first_q || (bus.po_vec != last_q));
    // A full FIFO still takes the push when the head leaves in the same cycle.
    push       = want_push && ((level_q != LW'(DEPTH)) || pop);
    drop       = want_push && !push;
    push_entry = '{vec: bus.po_vec, ts: ts_q, first: first_q};
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    // The new head is the entry being written right now when it lands at rd_ptr_d.
    head_d     = (push && (wr_ptr_q == rd_ptr_d)) ? push_entry : mem_q[rd_ptr_d];
  end

  // NOTE: storage has no reset; validity is tracked by level/pointers, so stale
  // contents are never exposed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ts_q       <= '0;
      last_q     <= '0;
      first_q    <= 1'b1;
      ev_valid_q <= 1'b0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      if (bus.sample) begin
        ts_q    <= ts_q + 1'b1;
        last_q  <= bus.po_vec;
        first_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ev_valid_q <= (level_d != '0);
      if (level_d != '0) head_q <= head_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
    end
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_vec   = head_q.vec;
  assign bus.ev_ts    = head_q.ts;
  assign bus.ev_first = head_q.first;
  assign bus.level    = level_q;
  assign bus.ovf      = ovf_q;
  assign bus.ovf_cnt  = ovf_cnt_q;
endmodule

// File: tb/tb_apex7_po_event_capture.sv
// Directed bench for apex7_po_event_capture: a table of per-cycle vectors with
// hand-computed results, plus a hand-written timestamp-wrap sequence.
module tb_apex7_po_event_capture;
  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apex7_po_event_capture_if #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  apex7_po_event_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        sample;
    logic [36:0] po;
    logic        rdy;
    logic        e_valid;
    logic [36:0] e_vec;
    logic [7:0]  e_ts;
    logic        e_first;
    logic [2:0]  e_level;
    logic        e_ovf;
    logic [7:0]  e_cnt;
    logic        chk_ev;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic s, logic [36:0] p, logic rd,
                              logic v, logic [36:0] ev, logic [7:0] et, logic ef,
                              logic [2:0] lv, logic o, logic [7:0] c, logic ce);
    vec_t t;
    t = '{r, s, p, rd, v, ev, et, ef, lv, o, c, ce};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, then sample outputs 1 time unit later.
  task automatic apply(input logic r, input logic s, input logic [36:0] p, input logic rd);
    rst_n        = r;
    bus.sample   = s;
    bus.po_vec   = p;
    bus.ev_ready = rd;
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.sample   = 1'b0;
    bus.po_vec   = '0;
    bus.ev_ready = 1'b0;

    // rst samp po       rdy | valid vec ts first level ovf cnt chk_ev
    // Single event after reset, then popped.
    tbl.push_back(mk(0, 0, 37'h0, 0,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h0, 1,  1, 37'h0, 8'd0, 1, 3'd1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 0));
    // Repeated value produces no event; timestamp still advances.
    tbl.push_back(mk(0, 0, 37'h0, 0,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h1, 1,  1, 37'h1, 8'd0, 1, 3'd1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h1, 1,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 37'h3, 1,  1, 37'h3, 8'd2, 0, 3'd1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 0));
    // Fill with consumer stalled: six changes, two dropped.
    tbl.push_back(mk(0, 0, 37'h0, 0,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h1, 0,  1, 37'h1, 8'd0, 1, 3'd1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h2, 0,  1, 37'h1, 8'd0, 1, 3'd2, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h3, 0,  1, 37'h1, 8'd0, 1, 3'd3, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h4, 0,  1, 37'h1, 8'd0, 1, 3'd4, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h5, 0,  1, 37'h1, 8'd0, 1, 3'd4, 1, 8'd1, 1));
    tbl.push_back(mk(1, 1, 37'h6, 0,  1, 37'h1, 8'd0, 1, 3'd4, 1, 8'd2, 1));
    // Full + pop + push in one cycle: accepted, level stays 4, no new drop.
    tbl.push_back(mk(1, 1, 37'h7, 1,  1, 37'h2, 8'd1, 0, 3'd4, 1, 8'd2, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  1, 37'h3, 8'd2, 0, 3'd3, 1, 8'd2, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  1, 37'h4, 8'd3, 0, 3'd2, 1, 8'd2, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  1, 37'h7, 8'd6, 0, 3'd1, 1, 8'd2, 1));
    tbl.push_back(mk(1, 0, 37'h0, 1,  0, 37'h0, 8'd0, 0, 3'd0, 1, 8'd2, 0));
    // Mid-stream reset with three pending events; reset wins over sample.
    tbl.push_back(mk(0, 0, 37'h0, 0,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h1, 0,  1, 37'h1, 8'd0, 1, 3'd1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h2, 0,  1, 37'h1, 8'd0, 1, 3'd2, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h3, 0,  1, 37'h1, 8'd0, 1, 3'd3, 0, 8'd0, 1));
    tbl.push_back(mk(0, 1, 37'h9, 0,  0, 37'h0, 8'd0, 0, 3'd0, 0, 8'd0, 1));
    tbl.push_back(mk(1, 1, 37'h9, 0,  1, 37'h9, 8'd0, 1, 3'd1, 0, 8'd0, 1));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst_n, tbl[i].sample, tbl[i].po, tbl[i].rdy);
      check($sformatf("v%0d.valid", i), 64'(bus.ev_valid), 64'(tbl[i].e_valid));
      check($sformatf("v%0d.level", i), 64'(bus.level),    64'(tbl[i].e_level));
      check($sformatf("v%0d.ovf", i),   64'(bus.ovf),      64'(tbl[i].e_ovf));
      check($sformatf("v%0d.cnt", i),   64'(bus.ovf_cnt),  64'(tbl[i].e_cnt));
      if (tbl[i].chk_ev) begin
        check($sformatf("v%0d.vec", i),   64'(bus.ev_vec),   64'(tbl[i].e_vec));
        check($sformatf("v%0d.ts", i),    64'(bus.ev_ts),    64'(tbl[i].e_ts));
        check($sformatf("v%0d.first", i), 64'(bus.ev_first), 64'(tbl[i].e_first));
      end
    end

    // Timestamp wrap: 260 alternating samples, each one an event popped next cycle.
    apply(1'b0, 1'b0, 37'h0, 1'b0);
    for (int k = 0; k < 260; k++) begin
      logic [7:0]  exp_ts;
      logic [36:0] exp_vec;
      exp_ts  = 8'(k);
      exp_vec = 37'(k % 2);
      apply(1'b1, 1'b1, exp_vec, 1'b1);
      check($sformatf("wrap%0d.head", k),
            {16'(bus.level), 1'(bus.ev_valid), 8'(bus.ev_ts), 1'(bus.ev_first), 37'(bus.ev_vec)},
            {16'd1, 1'b1, exp_ts, (k == 0), exp_vec});
    end
    check("wrap.ovf",     64'(bus.ovf),     64'd0);
    check("wrap.ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
    apply(1'b1, 1'b0, 37'h0, 1'b1);
    check("wrap.drain_level", 64'(bus.level),    64'd0);
    check("wrap.drain_valid", 64'(bus.ev_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
